// File: rtl/uart_resp_encode.sv
// uart_resp_encode: sends one response (cmd, addr, data) per handshake to the
// host as a 5-byte UART frame: HEADER, cmd, addr, data, checksum, where the
// checksum is (cmd + addr + data) mod 256. Bytes go out LSB first, with no
// idle time between bytes.
// Build option: define UART_PARITY_EN to add an even-parity bit after the data
// bits (8E1, 11 bits per byte). Without it the line format is 8N1.
module uart_resp_encode #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       resp_valid,
  output logic       resp_ready,
  input  logic [7:0] resp_cmd,
  input  logic [7:0] resp_addr,
  input  logic [7:0] resp_data,
  output logic       uart_tx,
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT < 4) ? 2 : $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BYTE = 3'd4;

  // Reject baud settings too fast for the clock.
  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $error("uart_resp_encode: CLK_FREQ/BAUD must be at least 4");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_d;
  logic [2:0]       bit_idx, bit_idx_d;
  logic [2:0]       byte_idx, byte_idx_d;
  logic             tx_q, tx_d;
  logic [7:0]       cmd_q, addr_q, data_q, sum_q;
  logic [7:0]       cur_byte;
  logic             tick, frame_done, accept;

  assign tick       = (baud_cnt == LAST_CNT);
  // The last clock of the final stop bit counts as the return to IDLE, so a
  // waiting response is taken on that edge and the next start bit follows
  // without any idle time on the line.
  assign frame_done = (state == S_STOP) && tick && (byte_idx == LAST_BYTE);
  assign resp_ready = (state == S_IDLE) || frame_done;
  assign accept     = resp_valid && resp_ready;
  assign busy       = (state != S_IDLE);
  assign uart_tx    = tx_q;

  // Select the byte currently on the wire.
  always_comb begin
    case (byte_idx)
      3'd0:    cur_byte = HEADER;
      3'd1:    cur_byte = cmd_q;
      3'd2:    cur_byte = addr_q;
      3'd3:    cur_byte = data_q;
      default: cur_byte = sum_q;
    endcase
  end

  // Next state, baud counter, bit/byte indices and next line level.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    state_d    = state;
    baud_cnt_d = tick ? '0 : baud_cnt + CNT_W'(1);
    bit_idx_d  = bit_idx;
    byte_idx_d = byte_idx;
    tx_d       = tx_q;
    case (state)
      S_IDLE: begin
        baud_cnt_d = '0;
        tx_d       = 1'b1;
        if (accept) begin
          state_d    = S_START;
          byte_idx_d = '0;
          bit_idx_d  = '0;
          tx_d       = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
          tx_d      = cur_byte[0];
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = S_PARITY;
            tx_d    = ^cur_byte;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx + 3'd1;
            tx_d      = cur_byte[bit_idx + 3'd1];
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (byte_idx != LAST_BYTE) begin
            state_d    = S_START;
            byte_idx_d = byte_idx + 3'd1;
            tx_d       = 1'b0;
          end else if (accept) begin
            state_d    = S_START;
            byte_idx_d = '0;
            bit_idx_d  = '0;
            tx_d       = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State register and registered line driver; reset drops any frame in flight.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      tx_q     <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state    <= state_d;
      baud_cnt <= baud_cnt_d;
      bit_idx  <= bit_idx_d;
      byte_idx <= byte_idx_d;
      tx_q     <= tx_d;
    end
  end

  // Capture the response and its checksum on accept; later input changes are ignored.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      sum_q  <= '0;
    end else if (accept) begin
      cmd_q  <= resp_cmd;
      addr_q <= resp_addr;
      data_q <= resp_data;
      sum_q  <= resp_cmd + resp_addr + resp_data;
    end
  end

endmodule
